// File: rtl/huff_sort_pkg.sv
// rtl/huff_sort_pkg.sv - shared types and constants for the framed frequency sorter
package huff_sort_pkg;

    typedef enum logic [1:0] {
        COUNT = 2'd0,
        SORT  = 2'd1,
        HOLD  = 2'd2
    } sort_state_t;

    localparam logic MODE_ASCENDING  = 1'b0;
    localparam logic MODE_DESCENDING = 1'b1;

    function automatic int count_width(input int symbols);
        return $clog2(symbols + 1);
    endfunction

endpackage

// File: rtl/framed_freq_sorter_oets_cmp_swap.sv
// rtl/framed_freq_sorter_oets_cmp_swap.sv - one compare-exchange cell of the odd-even transposition network
module oets_cmp_swap
    import huff_sort_pkg::*;
#(
    parameter int FREQ_WIDTH   = 32,
    parameter int SYMBOL_WIDTH = 5
) (
    input  logic                    mode,
    input  logic [FREQ_WIDTH-1:0]   freq_a,
    input  logic [SYMBOL_WIDTH-1:0] sym_a,
    input  logic [FREQ_WIDTH-1:0]   freq_b,
    input  logic [SYMBOL_WIDTH-1:0] sym_b,
    output logic [FREQ_WIDTH-1:0]   freq_first,
    output logic [SYMBOL_WIDTH-1:0] sym_first,
    output logic [FREQ_WIDTH-1:0]   freq_second,
    output logic [SYMBOL_WIDTH-1:0] sym_second,
    output logic                    swap
);

    logic tie_swap;

    // Equal frequencies always resolve to ascending symbol, whatever the mode.
    always_comb begin
        tie_swap = (freq_a == freq_b) && (sym_a > sym_b);
        if (mode == MODE_DESCENDING)
            swap = (freq_a < freq_b) || tie_swap;
        else
            swap = (freq_a > freq_b) || tie_swap;
        freq_first  = swap ? freq_b : freq_a;
        sym_first   = swap ? sym_b  : sym_a;
        freq_second = swap ? freq_a : freq_b;
        sym_second  = swap ? sym_a  : sym_b;
    end

endmodule

// File: rtl/framed_freq_sorter.sv
// rtl/framed_freq_sorter.sv - per-frame symbol histogram followed by an odd-even transposition sort
module framed_freq_sorter
    import huff_sort_pkg::*;
#(
    parameter int SYMBOLS      = 16,
    parameter int SYMBOL_WIDTH = 5,
    parameter int FREQ_WIDTH   = 32,
    parameter int DESCENDING   = 0,
    parameter int EARLY_EXIT   = 1
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic [SYMBOL_WIDTH-1:0]            symbol_in,
    input  logic                               valid_in,
    input  logic                               last_in,
    output logic                               ready_in,
    output logic [SYMBOLS*FREQ_WIDTH-1:0]      sorted_frequencies_flat,
    output logic [SYMBOLS*SYMBOL_WIDTH-1:0]    sorted_symbol_flat,
    output logic [count_width(SYMBOLS)-1:0]    nonzero_count,
    output logic                               sorted_valid,
    input  logic                               sorted_ack,
    output logic                               sorted_done,
    output logic                               overflow,
    output logic                               bad_symbol
);

    localparam int  PW        = $clog2(SYMBOLS + 1);
    localparam int  NZW       = count_width(SYMBOLS);
    localparam logic SORT_MODE = (DESCENDING != 0) ? MODE_DESCENDING : MODE_ASCENDING;

    sort_state_t state, next_state;

    logic [FREQ_WIDTH-1:0]   freq   [SYMBOLS];
    logic [SYMBOL_WIDTH-1:0] sym    [SYMBOLS];
    logic [FREQ_WIDTH-1:0]   ev_f   [SYMBOLS];
    logic [SYMBOL_WIDTH-1:0] ev_s   [SYMBOLS];
    logic [FREQ_WIDTH-1:0]   od_f   [SYMBOLS];
    logic [SYMBOL_WIDTH-1:0] od_s   [SYMBOLS];
    logic [FREQ_WIDTH-1:0]   net_f  [SYMBOLS];
    logic [SYMBOL_WIDTH-1:0] net_s  [SYMBOLS];
    logic [SYMBOLS/2-1:0]    ev_swap;
    logic [SYMBOLS/2-2:0]    od_swap;
    logic                    any_swap;
    logic                    quiet;
    logic [PW-1:0]           phase;
    logic [NZW-1:0]          nz_next;

    for (genvar j = 0; j < SYMBOLS / 2; j++) begin : g_even
        oets_cmp_swap #(.FREQ_WIDTH(FREQ_WIDTH), .SYMBOL_WIDTH(SYMBOL_WIDTH)) u_cell (
            .mode(SORT_MODE),
            .freq_a(freq[2*j]),      .sym_a(sym[2*j]),
            .freq_b(freq[2*j+1]),    .sym_b(sym[2*j+1]),
            .freq_first(ev_f[2*j]),  .sym_first(ev_s[2*j]),
            .freq_second(ev_f[2*j+1]), .sym_second(ev_s[2*j+1]),
            .swap(ev_swap[j])
        );
    end

    for (genvar j = 0; j < SYMBOLS / 2 - 1; j++) begin : g_odd
        oets_cmp_swap #(.FREQ_WIDTH(FREQ_WIDTH), .SYMBOL_WIDTH(SYMBOL_WIDTH)) u_cell (
            .mode(SORT_MODE),
            .freq_a(freq[2*j+1]),    .sym_a(sym[2*j+1]),
            .freq_b(freq[2*j+2]),    .sym_b(sym[2*j+2]),
            .freq_first(od_f[2*j+1]), .sym_first(od_s[2*j+1]),
            .freq_second(od_f[2*j+2]), .sym_second(od_s[2*j+2]),
            .swap(od_swap[j])
        );
    end

    // The end entries sit out odd phases.
    assign od_f[0]         = freq[0];
    assign od_s[0]         = sym[0];
    assign od_f[SYMBOLS-1] = freq[SYMBOLS-1];
    assign od_s[SYMBOLS-1] = sym[SYMBOLS-1];
    assign any_swap        = phase[0] ? |od_swap : |ev_swap;

    always_comb begin
        nz_next = '0;
        for (int i = 0; i < SYMBOLS; i++) begin
            net_f[i] = phase[0] ? od_f[i] : ev_f[i];
            net_s[i] = phase[0] ? od_s[i] : ev_s[i];
            sorted_frequencies_flat[i*FREQ_WIDTH +: FREQ_WIDTH] = freq[i];
            sorted_symbol_flat[i*SYMBOL_WIDTH +: SYMBOL_WIDTH]  = sym[i];
            if (freq[i] != '0)
                nz_next = nz_next + NZW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset)
            state <= COUNT;
        else
            state <= next_state;
    end

    always_comb begin
        next_state   = state;
        ready_in     = 1'b0;
        sorted_valid = 1'b0;
        case (state)
            COUNT: begin
                ready_in = 1'b1;
                if (valid_in && last_in)
                    next_state = SORT;
            end
            SORT: begin
                if (phase == PW'(SYMBOLS - 1) || (EARLY_EXIT != 0 && quiet && !any_swap))
                    next_state = HOLD;
            end
            HOLD: begin
                sorted_valid = 1'b1;
                if (sorted_ack)
                    next_state = COUNT;
            end
            default: next_state = COUNT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset || (state == HOLD && sorted_ack)) begin
            for (int i = 0; i < SYMBOLS; i++) begin
                freq[i] <= '0;
                sym[i]  <= SYMBOL_WIDTH'(i);
            end
            phase         <= '0;
            quiet         <= 1'b0;
            overflow      <= 1'b0;
            bad_symbol    <= 1'b0;
            nonzero_count <= '0;
            sorted_done   <= 1'b0;
        end else begin
            sorted_done <= (state == SORT) && (next_state == HOLD);
            case (state)
                COUNT: begin
                    phase <= '0;
                    quiet <= 1'b0;
                    if (valid_in) begin
                        if (32'(symbol_in) >= SYMBOLS)
                            bad_symbol <= 1'b1;
                        for (int i = 0; i < SYMBOLS; i++) begin
                            if (symbol_in == SYMBOL_WIDTH'(i)) begin
                                if (freq[i] == '1)
                                    overflow <= 1'b1;
                                else
                                    freq[i] <= freq[i] + FREQ_WIDTH'(1);
                            end
                        end
                    end
                end
                SORT: begin
                    for (int i = 0; i < SYMBOLS; i++) begin
                        freq[i] <= net_f[i];
                        sym[i]  <= net_s[i];
                    end
                    phase <= phase + PW'(1);
                    quiet <= !any_swap;
                    if (next_state == HOLD)
                        nonzero_count <= nz_next;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_framed_freq_sorter.sv
// tb/tb_framed_freq_sorter.sv - scoreboard bench for framed_freq_sorter across several parameter sets
module tb_framed_freq_sorter;

    typedef struct {
        logic [31:0] f;
        logic [4:0]  s;
    } entry_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        last_in = 1'b0;
    logic        sorted_ack = 1'b0;
    logic [4:0]  symbol_in = '0;
    logic [4:0]  valid_vec = '0;
    logic [4:0]  rdy, sv, sd, ov, bs;

    logic [16*32-1:0] sf_a, sf_d, sf_e;
    logic [16*5-1:0]  ss_a, ss_d, ss_e, ss_w;
    logic [16*4-1:0]  sf_w;
    logic [12*32-1:0] sf_b;
    logic [12*5-1:0]  ss_b;
    logic [4:0]       nz_a, nz_d, nz_e, nz_w;
    logic [3:0]       nz_b;

    int          errors = 0;
    int          checks = 0;
    int          stim[$];
    entry_t      exp_q[$];
    logic [31:0] exp_f[16];
    logic [4:0]  exp_s[16];
    int          exp_nz;
    logic        exp_ov, exp_bs;
    logic [31:0] got_f[16];
    logic [4:0]  got_s[16];
    int          got_nz;

    always #5 clk = ~clk;

    framed_freq_sorter #(.EARLY_EXIT(0)) dut_a (
        .clk(clk), .reset(reset), .symbol_in(symbol_in), .valid_in(valid_vec[0]), .last_in(last_in),
        .ready_in(rdy[0]), .sorted_frequencies_flat(sf_a), .sorted_symbol_flat(ss_a), .nonzero_count(nz_a),
        .sorted_valid(sv[0]), .sorted_ack(sorted_ack), .sorted_done(sd[0]), .overflow(ov[0]), .bad_symbol(bs[0]));

    framed_freq_sorter #(.DESCENDING(1), .EARLY_EXIT(0)) dut_d (
        .clk(clk), .reset(reset), .symbol_in(symbol_in), .valid_in(valid_vec[1]), .last_in(last_in),
        .ready_in(rdy[1]), .sorted_frequencies_flat(sf_d), .sorted_symbol_flat(ss_d), .nonzero_count(nz_d),
        .sorted_valid(sv[1]), .sorted_ack(sorted_ack), .sorted_done(sd[1]), .overflow(ov[1]), .bad_symbol(bs[1]));

    framed_freq_sorter #(.EARLY_EXIT(1)) dut_e (
        .clk(clk), .reset(reset), .symbol_in(symbol_in), .valid_in(valid_vec[2]), .last_in(last_in),
        .ready_in(rdy[2]), .sorted_frequencies_flat(sf_e), .sorted_symbol_flat(ss_e), .nonzero_count(nz_e),
        .sorted_valid(sv[2]), .sorted_ack(sorted_ack), .sorted_done(sd[2]), .overflow(ov[2]), .bad_symbol(bs[2]));

    framed_freq_sorter #(.FREQ_WIDTH(4), .EARLY_EXIT(0)) dut_w (
        .clk(clk), .reset(reset), .symbol_in(symbol_in), .valid_in(valid_vec[3]), .last_in(last_in),
        .ready_in(rdy[3]), .sorted_frequencies_flat(sf_w), .sorted_symbol_flat(ss_w), .nonzero_count(nz_w),
        .sorted_valid(sv[3]), .sorted_ack(sorted_ack), .sorted_done(sd[3]), .overflow(ov[3]), .bad_symbol(bs[3]));

    framed_freq_sorter #(.SYMBOLS(12), .EARLY_EXIT(0)) dut_b (
        .clk(clk), .reset(reset), .symbol_in(symbol_in), .valid_in(valid_vec[4]), .last_in(last_in),
        .ready_in(rdy[4]), .sorted_frequencies_flat(sf_b), .sorted_symbol_flat(ss_b), .nonzero_count(nz_b),
        .sorted_valid(sv[4]), .sorted_ack(sorted_ack), .sorted_done(sd[4]), .overflow(ov[4]), .bad_symbol(bs[4]));

    // Reference: histogram with saturation, then a plain insertion sort on (freq, symbol).
    task automatic model_frame(input int nsym, input longint fmax, input bit desc);
        longint f[16];
        int     s[16];
        longint tf;
        int     ts;
        entry_t e;
        exp_nz = 0; exp_ov = 1'b0; exp_bs = 1'b0;
        for (int i = 0; i < 16; i++) begin f[i] = 0; s[i] = i; end
        foreach (stim[k]) begin
            if (stim[k] >= nsym) exp_bs = 1'b1;
            else if (f[stim[k]] == fmax) exp_ov = 1'b1;
            else f[stim[k]]++;
        end
        for (int i = 0; i < nsym; i++) if (f[i] != 0) exp_nz++;
        for (int i = 1; i < nsym; i++) begin
            for (int j = i; j > 0; j--) begin
                bit bef;
                if (desc) bef = (f[j] > f[j-1]) || (f[j] == f[j-1] && s[j] < s[j-1]);
                else      bef = (f[j] < f[j-1]) || (f[j] == f[j-1] && s[j] < s[j-1]);
                if (!bef) break;
                tf = f[j]; f[j] = f[j-1]; f[j-1] = tf;
                ts = s[j]; s[j] = s[j-1]; s[j-1] = ts;
            end
        end
        for (int i = 0; i < nsym; i++) begin
            e.f = f[i][31:0];
            e.s = s[i][4:0];
            exp_q.push_back(e);
            exp_f[i] = e.f;
            exp_s[i] = e.s;
        end
    endtask

    task automatic drive_frame(input int which);
        for (int k = 0; k < stim.size(); k++) begin
            symbol_in = stim[k][4:0];
            valid_vec = 5'b1 << which;
            last_in   = (k == stim.size() - 1);
            @(posedge clk); #1;
        end
        valid_vec = '0;
        last_in   = 1'b0;
    endtask

    task automatic wait_valid(input int which, output int n, output int pulses);
        n = -1;
        pulses = 0;
        for (int c = 1; c <= 200; c++) begin
            @(posedge clk); #1;
            if (sd[which]) pulses++;
            if (sv[which]) begin n = c; break; end
        end
    endtask

    task automatic capture(input int which);
        for (int i = 0; i < 16; i++) begin
            case (which)
                0: begin got_f[i] = sf_a[i*32 +: 32]; got_s[i] = ss_a[i*5 +: 5]; end
                1: begin got_f[i] = sf_d[i*32 +: 32]; got_s[i] = ss_d[i*5 +: 5]; end
                2: begin got_f[i] = sf_e[i*32 +: 32]; got_s[i] = ss_e[i*5 +: 5]; end
                3: begin got_f[i] = {28'd0, sf_w[i*4 +: 4]}; got_s[i] = ss_w[i*5 +: 5]; end
                default: begin
                    got_f[i] = (i < 12) ? sf_b[i*32 +: 32] : 32'd0;
                    got_s[i] = (i < 12) ? ss_b[i*5 +: 5] : 5'd0;
                end
            endcase
        end
        case (which)
            0: got_nz = int'(nz_a);
            1: got_nz = int'(nz_d);
            2: got_nz = int'(nz_e);
            3: got_nz = int'(nz_w);
            default: got_nz = int'(nz_b);
        endcase
    endtask

    task automatic pulse_ack();
        sorted_ack = 1'b1;
        @(posedge clk); #1;
        sorted_ack = 1'b0;
    endtask

    task automatic load_main_stream();
        stim = '{0, 15, 1, 1, 2, 2, 3, 3, 4, 5, 6, 7, 8, 9, 0, 0};
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        checks++;
        if (rdy !== 5'b11111 || sv !== 5'b0 || sd !== 5'b0 || ov !== 5'b0 || bs !== 5'b0) begin
            errors++;
            $display("FAIL reset_flags: rdy=%b sv=%b sd=%b ov=%b bs=%b required rdy=11111 others 0", rdy, sv, sd, ov, bs);
        end
        capture(0);
        for (int i = 0; i < 16; i++) begin
            checks++;
            if (got_f[i] !== 32'd0 || got_s[i] !== 5'(i)) begin
                errors++;
                $display("FAIL reset_entry%0d: freq=%0d sym=%0d required freq=0 sym=%0d", i, got_f[i], got_s[i], i);
            end
        end
        checks++;
        if (got_nz !== 0) begin
            errors++;
            $display("FAIL reset_nz: got %0d required 0", got_nz);
        end
    endtask

    task automatic test_ascending();
        int n, pulses;
        entry_t e;
        load_main_stream();
        model_frame(16, 64'hFFFF_FFFF, 1'b0);
        drive_frame(0);
        wait_valid(0, n, pulses);
        repeat (5) begin
            @(posedge clk); #1;
            if (sd[0]) pulses++;
        end
        checks++;
        if (n !== 16) begin errors++; $display("FAIL asc_latency: got %0d cycles required 16", n); end
        checks++;
        if (pulses !== 1) begin errors++; $display("FAIL asc_done_pulse: got %0d pulses required 1", pulses); end
        capture(0);
        for (int i = 0; i < 16; i++) begin
            e = exp_q.pop_front();
            checks++;
            if (got_f[i] !== e.f || got_s[i] !== e.s) begin
                errors++;
                $display("FAIL asc_entry%0d: freq=%0d sym=%0d required freq=%0d sym=%0d", i, got_f[i], got_s[i], e.f, e.s);
            end
        end
        checks++;
        if (got_f[15] !== 32'd3 || got_s[15] !== 5'd0) begin
            errors++;
            $display("FAIL asc_top: freq=%0d sym=%0d required freq=3 sym=0", got_f[15], got_s[15]);
        end
        checks++;
        if (got_nz !== 11) begin errors++; $display("FAIL asc_nz: got %0d required 11", got_nz); end
        pulse_ack();
    endtask

    task automatic test_descending();
        int n, pulses;
        entry_t e;
        load_main_stream();
        model_frame(16, 64'hFFFF_FFFF, 1'b1);
        drive_frame(1);
        wait_valid(1, n, pulses);
        checks++;
        if (n !== 16) begin errors++; $display("FAIL desc_latency: got %0d cycles required 16", n); end
        capture(1);
        for (int i = 0; i < 16; i++) begin
            e = exp_q.pop_front();
            checks++;
            if (got_f[i] !== e.f || got_s[i] !== e.s) begin
                errors++;
                $display("FAIL desc_entry%0d: freq=%0d sym=%0d required freq=%0d sym=%0d", i, got_f[i], got_s[i], e.f, e.s);
            end
        end
        checks++;
        if (got_nz !== exp_nz) begin errors++; $display("FAIL desc_nz: got %0d required %0d", got_nz, exp_nz); end
        pulse_ack();
    endtask

    task automatic test_early_exit();
        int n, pulses;
        entry_t e;
        stim.delete();
        for (int k = 0; k < 16; k++) stim.push_back(k);
        model_frame(16, 64'hFFFF_FFFF, 1'b0);
        drive_frame(2);
        wait_valid(2, n, pulses);
        checks++;
        if (n !== 2) begin errors++; $display("FAIL early_latency: got %0d cycles required 2", n); end
        capture(2);
        for (int i = 0; i < 16; i++) begin
            e = exp_q.pop_front();
            checks++;
            if (got_f[i] !== e.f || got_s[i] !== e.s) begin
                errors++;
                $display("FAIL early_entry%0d: freq=%0d sym=%0d required freq=%0d sym=%0d", i, got_f[i], got_s[i], e.f, e.s);
            end
        end
        pulse_ack();
    endtask

    task automatic test_saturation_and_bad_symbol();
        int n, pulses;
        entry_t e;
        stim.delete();
        for (int k = 0; k < 20; k++) stim.push_back(5);
        model_frame(16, 15, 1'b0);
        drive_frame(3);
        wait_valid(3, n, pulses);
        capture(3);
        for (int i = 0; i < 16; i++) begin
            e = exp_q.pop_front();
            checks++;
            if (got_f[i] !== e.f || got_s[i] !== e.s) begin
                errors++;
                $display("FAIL sat_entry%0d: freq=%0d sym=%0d required freq=%0d sym=%0d", i, got_f[i], got_s[i], e.f, e.s);
            end
        end
        checks++;
        if (ov[3] !== 1'b1 || got_f[15] !== 32'd15) begin
            errors++;
            $display("FAIL sat_overflow: overflow=%b top freq=%0d required overflow=1 freq=15", ov[3], got_f[15]);
        end
        pulse_ack();

        stim = '{3, 13, 3};
        model_frame(12, 64'hFFFF_FFFF, 1'b0);
        drive_frame(4);
        wait_valid(4, n, pulses);
        capture(4);
        for (int i = 0; i < 12; i++) begin
            e = exp_q.pop_front();
            checks++;
            if (got_f[i] !== e.f || got_s[i] !== e.s) begin
                errors++;
                $display("FAIL bad_entry%0d: freq=%0d sym=%0d required freq=%0d sym=%0d", i, got_f[i], got_s[i], e.f, e.s);
            end
        end
        checks++;
        if (bs[4] !== exp_bs || ov[4] !== exp_ov || got_nz !== exp_nz) begin
            errors++;
            $display("FAIL bad_flags: bad=%b ovf=%b nz=%0d required bad=%b ovf=%b nz=%0d", bs[4], ov[4], got_nz, exp_bs, exp_ov, exp_nz);
        end
        pulse_ack();
    endtask

    task automatic test_hold_and_back_to_back();
        int n, pulses, bad;
        entry_t e;
        stim = '{7, 3, 3};
        model_frame(16, 64'hFFFF_FFFF, 1'b0);
        drive_frame(0);
        wait_valid(0, n, pulses);
        for (int i = 0; i < 16; i++) e = exp_q.pop_front();
        for (int c = 0; c < 50; c++) begin
            symbol_in = 5'($urandom_range(0, 15));
            valid_vec = 5'b00001;
            last_in   = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
            capture(0);
            bad = 0;
            for (int i = 0; i < 16; i++)
                if (got_f[i] !== exp_f[i] || got_s[i] !== exp_s[i]) bad++;
            checks++;
            if (bad != 0 || rdy[0] !== 1'b0 || sv[0] !== 1'b1) begin
                errors++;
                $display("FAIL hold_frozen cycle %0d: %0d entries differ ready=%b valid=%b required 0 differ ready=0 valid=1", c, bad, rdy[0], sv[0]);
            end
        end
        valid_vec = '0;
        last_in   = 1'b0;
        pulse_ack();
        checks++;
        if (rdy[0] !== 1'b1 || sv[0] !== 1'b0 || nz_a !== 5'd0) begin
            errors++;
            $display("FAIL ack_release: ready=%b valid=%b nz=%0d required ready=1 valid=0 nz=0", rdy[0], sv[0], nz_a);
        end
        stim = '{7, 7};
        model_frame(16, 64'hFFFF_FFFF, 1'b0);
        drive_frame(0);
        wait_valid(0, n, pulses);
        capture(0);
        for (int i = 0; i < 16; i++) begin
            e = exp_q.pop_front();
            checks++;
            if (got_f[i] !== e.f || got_s[i] !== e.s) begin
                errors++;
                $display("FAIL b2b_entry%0d: freq=%0d sym=%0d required freq=%0d sym=%0d", i, got_f[i], got_s[i], e.f, e.s);
            end
        end
        checks++;
        if (got_nz !== 1) begin errors++; $display("FAIL b2b_nz: got %0d required 1", got_nz); end
        pulse_ack();
    endtask

    task automatic test_reset_mid_sort();
        int bad;
        load_main_stream();
        drive_frame(0);
        repeat (5) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        checks++;
        if (rdy[0] !== 1'b1 || sv[0] !== 1'b0 || nz_a !== 5'd0) begin
            errors++;
            $display("FAIL midsort_state: ready=%b valid=%b nz=%0d required ready=1 valid=0 nz=0", rdy[0], sv[0], nz_a);
        end
        capture(0);
        bad = 0;
        for (int i = 0; i < 16; i++)
            if (got_f[i] !== 32'd0 || got_s[i] !== 5'(i)) bad++;
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL midsort_arrays: %0d entries not cleared required 0", bad);
        end
    endtask

    initial begin
        test_reset();
        test_ascending();
        test_descending();
        test_early_exit();
        test_saturation_and_bad_symbol();
        test_hold_and_back_to_back();
        test_reset_mid_sort();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
